gate_vector_driver: RTL
=======================

Name: gate_vector_driver

Overview:
- Initiator side of the registered NOR/NAND/OR gate stage: generates 4-bit stimulus vectors onto in1..in4 and checks the returned out1..out3 against a built-in reference model.
- Sits in the self-test path in front of the gate stage, which registers its results one clock later.
- Reports an error count, the first failing vector index, and a pass flag.

Parameters:
- NUM_VECTORS, 16, vectors issued per run (1..2^IDX_W).
- IDX_W, 8, width of the vector index and first_err_idx.
- CNT_W, 8, width of the saturating error counter.
- RESP_LAT, 2, edges from a vector being registered on drive_* to its response being sampled (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request.
- mode  in  1  0 = counting vectors, 1 = LFSR vectors; sampled with start.
- drive_in1, drive_in2, drive_in3, drive_in4  out  1 each  stimulus to the gate stage (registered).
- resp_out1, resp_out2, resp_out3  in  1 each  registered results from the gate stage.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE, held until the next accepted start.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  CNT_W  mismatching vectors, saturating.
- first_err_idx  out  IDX_W  index of the first mismatching vector; all-ones if none.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: state=IDLE; drive_* = 0; busy, done, pass = 0; err_cnt = 0; first_err_idx = all-ones; idx = 0; LFSR = 4'b0001; check pipeline valid bits cleared.
- Vector bit mapping: in1=vec[0], in2=vec[1], in3=vec[2], in4=vec[3].
- Mode 0 vector: vec = idx[3:0].
- Mode 1 vector: vec = LFSR. LFSR is seeded 4'b0001 on start and advanced per issued vector as next = {lfsr[2:0], lfsr[3]^lfsr[2]}.
- Expected response: exp1 = ~(in1|in2); exp2 = ~(in2&in3); exp3 = in3|in4.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE --start--> RUN. On that same edge: clear err_cnt, done, pass; first_err_idx ← all-ones; latch mode; register vector 0 onto drive_*.
  - RUN: one vector per cycle, idx increments. After vector NUM_VECTORS-1 is registered → DRAIN; drive_* ← 0.
  - DRAIN: stays until the last vector's check edge, then → DONE.
- Timing relative to start edge = edge 0:
  - Vector k is registered at edge k.
  - Its response is compared at edge k+RESP_LAT.
  - Last compare is at edge NUM_VECTORS-1+RESP_LAT; done and pass are valid after that edge.
- Check pipeline: RESP_LAT stages carrying {valid, idx, exp1..3}. A compare happens only when the stage output is valid.
- Mismatch (any bit differs):
  - err_cnt increments, saturating at 2^CNT_W-1.
  - first_err_idx is loaded only if still all-ones.
- start while busy: ignored.
- start while in DONE: restarts a run.
- Reset mid-run: immediate return to reset values; partial results are discarded.
- drive_* are 0 in all states except RUN.

Optional Feature:
- Macro: GATE_VECTOR_ERR_INJECT_EN.
- Defined:
  - Adds input port inject_err (1 bit).
  - When inject_err is high on the edge a vector is registered, that vector's exp1 is inverted in the check pipeline, forcing exactly one mismatch for that vector against a correct gate stage.
- Undefined: the port is absent and expected values are never modified.

Test Plan:
- Reset, mode=0, start pulse at edge 0, correct gate stage, defaults → drive vec 0..15 on edges 0..15; done=1 after edge 17; err_cnt=0, pass=1, first_err_idx=8'hFF.
- mode=0, resp_out2 forced 0 → err_cnt=12 (idx 6, 7, 14, 15 match), first_err_idx=0, pass=0.
- mode=0, resp_out3 forced 1 → err_cnt=4, first_err_idx=0; with CNT_W=2 and resp_out2 forced 0 → err_cnt saturates at 3.
- mode=1, correct gate stage → first vectors 0001, 0010, 0100, 1001, 0011; err_cnt=0, pass=1; start pulsed at edge 5 is ignored.
- rst_n low at edge 7 of a run → all outputs at reset values immediately; fresh start then completes with pass=1.
- GATE_VECTOR_ERR_INJECT_EN defined, inject_err high on edge 3 only → err_cnt=1, first_err_idx=3.

Source files
------------

// File: rtl/gate_vector_driver.sv
// Self-test initiator: drives 4-bit vectors into the NOR/NAND/OR gate stage and checks responses against a reference.
// Latency: vector k registered k edges after start; its check lands RESP_LAT edges later; done after edge NUM_VECTORS-1+RESP_LAT.
// Backpressure: none, one vector per cycle; start ignored while busy. Optional GATE_VECTOR_ERR_INJECT_EN adds i_inject_err.
module gate_vector_driver #(
  parameter int NUM_VECTORS = 16,
  parameter int IDX_W       = 8,
  parameter int CNT_W       = 8,
  parameter int RESP_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_mode,
`ifdef GATE_VECTOR_ERR_INJECT_EN
  input  logic             i_inject_err,
`endif
  output logic             o_drive_in1,
  output logic             o_drive_in2,
  output logic             o_drive_in3,
  output logic             o_drive_in4,
  input  logic             i_resp_out1,
  input  logic             i_resp_out2,
  input  logic             i_resp_out3,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [IDX_W-1:0] o_first_err_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic [2:0]       exp;
  } chk_t;

  // r_cnt is one bit wider than the index so NUM_VECTORS = 2^IDX_W is representable
  localparam logic [IDX_W:0]   LAST_CNT = (IDX_W+1)'(NUM_VECTORS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W:0]   r_cnt;
  logic [3:0]       r_lfsr;
  logic             r_mode;
  logic [3:0]       r_drive;
  logic [CNT_W-1:0] r_err_cnt;
  logic [IDX_W-1:0] r_first_err_idx;
  chk_t             r_pipe [RESP_LAT];

  logic             w_start_acc;
  logic             w_issue_run;
  logic             w_issue;
  logic [3:0]       w_vec;
  logic [3:0]       w_lfsr_src;
  logic [3:0]       w_lfsr_nxt;
  logic [2:0]       w_exp;
  logic [IDX_W-1:0] w_cur_idx;
  chk_t             w_chk;
  logic [2:0]       w_resp;
  logic             w_mismatch;
  logic             w_last_chk;
  logic             w_inj;

`ifdef GATE_VECTOR_ERR_INJECT_EN
  assign w_inj = i_inject_err;
`else
  assign w_inj = 1'b0;
`endif

  assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_issue_run = (r_state == S_RUN) && (r_cnt != LAST_CNT);
  assign w_issue     = w_start_acc || w_issue_run;

  // The start edge registers vector 0, so the LFSR seed is used directly there
  assign w_lfsr_src = w_start_acc ? 4'b0001 : r_lfsr;
  assign w_lfsr_nxt = {w_lfsr_src[2:0], w_lfsr_src[3] ^ w_lfsr_src[2]};
  assign w_cur_idx  = w_start_acc ? '0 : r_cnt[IDX_W-1:0];

  always_comb begin
    w_vec = 4'b0000;
    if (w_start_acc) begin
      w_vec = i_mode ? 4'b0001 : 4'b0000;
    end else begin
      w_vec = r_mode ? r_lfsr : r_cnt[3:0];
    end
  end

  assign w_exp = {w_vec[2] | w_vec[3], ~(w_vec[1] & w_vec[2]), ~(w_vec[0] | w_vec[1]) ^ w_inj};

  assign w_chk      = r_pipe[RESP_LAT-1];
  assign w_resp     = {i_resp_out3, i_resp_out2, i_resp_out1};
  assign w_mismatch = w_chk.vld && (w_resp != w_chk.exp);
  assign w_last_chk = w_chk.vld && (w_chk.idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start_acc) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // With RESP_LAT=1 the final check coincides with leaving RUN
        if (r_cnt == LAST_CNT) w_state_nxt = w_last_chk ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        if (w_last_chk) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= 4'b0001;
      r_mode  <= 1'b0;
      r_drive <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_drive <= w_issue ? w_vec : 4'b0000;
      if (w_start_acc) begin
        r_cnt  <= (IDX_W+1)'(1);
        r_mode <= i_mode;
      end else if (w_issue_run) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_issue) r_lfsr <= w_lfsr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RESP_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= '{vld: w_issue, idx: w_cur_idx, exp: w_exp};
      for (int i = 1; i < RESP_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt       <= '0;
      r_first_err_idx <= '1;
    end else if (w_start_acc) begin
      r_err_cnt       <= '0;
      r_first_err_idx <= '1;
    end else if (w_mismatch) begin
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
      if (r_first_err_idx == '1) r_first_err_idx <= w_chk.idx;
    end
  end

  assign o_drive_in1     = r_drive[0];
  assign o_drive_in2     = r_drive[1];
  assign o_drive_in3     = r_drive[2];
  assign o_drive_in4     = r_drive[3];
  assign o_busy          = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done          = (r_state == S_DONE);
  assign o_pass          = o_done && (r_err_cnt == '0);
  assign o_err_cnt       = r_err_cnt;
  assign o_first_err_idx = r_first_err_idx;

endmodule
